// File: rtl/led_band_pkg.sv
// Shared types and geometry for the LED band GS shift path.
// Width constants are also used by led_band_controller.
package led_band_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOW  = 2'd1,
      HIGH = 2'd2,
      GAP  = 2'd3
   } seq_state_e;

   localparam int DEF_NB_LED_COLUMN = 32;
   localparam int DEF_BIT_PER_COLOR = 8;
   localparam int DEF_NB_0_LSB      = 1;
   localparam int DEF_NB_ANGLES     = 128;
   localparam int DEF_HALF_PERIOD   = 2;
   localparam int DEF_WRTGS_EDGES   = 1;
   localparam int DEF_LATGS_EDGES   = 3;

   // Counter width for n states, never below one bit.
   function automatic int clog2w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   localparam int NB_BITS         = DEF_BIT_PER_COLOR + DEF_NB_0_LSB;
   localparam int ANGLE_WIDTH     = clog2w(DEF_NB_ANGLES);
   localparam int ROW_WIDTH       = clog2w(DEF_NB_LED_COLUMN);
   localparam int BIT_SEL_WIDTH   = clog2w(NB_BITS);
   localparam int GS_BITS_PER_LED = 3 * NB_BITS;

endpackage

// File: rtl/led_band_sclk_gen.sv
// SCLK phase timer: holds each SCLK level for HALF_PERIOD clocks.
// Ticks flag the cycle before SCLK rises or falls.
module led_band_sclk_gen
   import led_band_pkg::*;
#(
   parameter int HALF_PERIOD = DEF_HALF_PERIOD
) (
   input  logic clk,
   input  logic rst,
   input  logic run_i,
   output logic sclk_o,
   output logic rise_tick_o,
   output logic fall_tick_o
);

   localparam int CW = clog2w(HALF_PERIOD);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          sclk_q, sclk_d;
   logic          wrap;

   assign wrap        = run_i && (cnt_q == CW'(HALF_PERIOD - 1));
   assign rise_tick_o = wrap && !sclk_q;
   assign fall_tick_o = wrap && sclk_q;
   assign sclk_o      = sclk_q;

   // Count phase cycles; idle forces SCLK low and rewinds the phase.
   always_comb begin
      cnt_d  = cnt_q + 1'b1;
      sclk_d = sclk_q;
      if (!run_i) begin
         cnt_d  = '0;
         sclk_d = 1'b0;
      end else if (wrap) begin
         cnt_d  = '0;
         sclk_d = !sclk_q;
      end
   end

   // Phase counter and SCLK register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q  <= '0;
         sclk_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         sclk_q <= sclk_d;
      end
   end

endmodule

// File: rtl/led_band_sequencer.sv
// Walks every LED/colour/bit of one angle slot at SCLK rate,
// framing each LED group with the driver's LAT command.
module led_band_sequencer
   import led_band_pkg::*;
#(
   parameter int NB_LED_COLUMN = DEF_NB_LED_COLUMN,
   parameter int BIT_PER_COLOR = DEF_BIT_PER_COLOR,
   parameter int NB_0_LSB      = DEF_NB_0_LSB,
   parameter int NB_ANGLES     = DEF_NB_ANGLES,
   parameter int HALF_PERIOD   = DEF_HALF_PERIOD,
   parameter int WRTGS_EDGES   = DEF_WRTGS_EDGES,
   parameter int LATGS_EDGES   = DEF_LATGS_EDGES
) (
   input  logic                                        clk,
   input  logic                                        rst,
   input  logic                                        en,
   input  logic [clog2w(NB_ANGLES)-1:0]                angle_in,
   input  logic                                        angle_strobe,
   output logic                                        SCLK,
   output logic                                        LAT,
   output logic [clog2w(NB_ANGLES)-1:0]                angle,
   output logic [clog2w(NB_LED_COLUMN)-1:0]            row,
   output logic [1:0]                                  color,
   output logic [clog2w(BIT_PER_COLOR+NB_0_LSB)-1:0]   bit_sel,
   output logic                                        busy,
   output logic                                        overrun
);

   localparam int NBITS  = BIT_PER_COLOR + NB_0_LSB;
   localparam int GS_LED = 3 * NBITS;
   localparam int AW     = clog2w(NB_ANGLES);
   localparam int RW     = clog2w(NB_LED_COLUMN);
   localparam int BW     = clog2w(NBITS);
   localparam int GW     = clog2w(2 * HALF_PERIOD);

   seq_state_e    state_q;
   logic [AW-1:0] angle_q;
   logic [RW-1:0] row_q, row_d;
   logic [1:0]    color_q, color_d;
   logic [BW-1:0] bit_q, bit_d;
   logic [GW-1:0] gap_q;
   logic          lat_q, lat_d;
   logic          busy_q;
   logic          ovr_q;
   logic          last_bit, last_col, last_row, pass_end;
   logic          run, abort;
   logic          rise_tick, fall_tick;
   int            lat_k;

   assign last_bit = (bit_q == BW'(NBITS - 1));
   assign last_col = (color_q == 2'd2);
   assign last_row = (row_q == RW'(NB_LED_COLUMN - 1));
   assign pass_end = last_bit && last_col && last_row;
   assign run      = en && (state_q == LOW || state_q == HIGH);
   assign abort    = (state_q != IDLE) && !en;

   led_band_sclk_gen #(
      .HALF_PERIOD (HALF_PERIOD)
   ) u_sclk (
      .clk         (clk),
      .rst         (rst),
      .run_i       (run),
      .sclk_o      (SCLK),
      .rise_tick_o (rise_tick),
      .fall_tick_o (fall_tick)
   );

   // Next bit index and the LAT level that goes with it.
   always_comb begin
      bit_d   = bit_q + 1'b1;
      color_d = color_q;
      row_d   = row_q;
      if (last_bit) begin
         bit_d = '0;
         if (last_col) begin
            color_d = 2'd0;
            row_d   = row_q + 1'b1;
         end else begin
            color_d = color_q + 2'd1;
         end
      end
      lat_k = (row_d == RW'(NB_LED_COLUMN - 1)) ? LATGS_EDGES
                                                : WRTGS_EDGES;
      lat_d = (int'(color_d) * NBITS + int'(bit_d)) >= (GS_LED - lat_k);
   end

   // Pass FSM with registered index, LAT, busy and overrun outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= IDLE;
         angle_q <= '0;
         row_q   <= '0;
         color_q <= '0;
         bit_q   <= '0;
         gap_q   <= '0;
         lat_q   <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
      end else begin
         ovr_q <= angle_strobe && busy_q;
         if (abort) begin
            state_q <= IDLE;
            row_q   <= '0;
            color_q <= '0;
            bit_q   <= '0;
            gap_q   <= '0;
            lat_q   <= 1'b0;
            busy_q  <= 1'b0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  if (angle_strobe && en) begin
                     state_q <= LOW;
                     angle_q <= angle_in;
                     row_q   <= '0;
                     color_q <= '0;
                     bit_q   <= '0;
                     busy_q  <= 1'b1;
                  end
               end
               LOW: begin
                  if (rise_tick) state_q <= HIGH;
               end
               HIGH: begin
                  if (fall_tick) begin
                     if (pass_end) begin
                        state_q <= GAP;
                        lat_q   <= 1'b0;
                        gap_q   <= '0;
                     end else begin
                        state_q <= LOW;
                        row_q   <= row_d;
                        color_q <= color_d;
                        bit_q   <= bit_d;
                        lat_q   <= lat_d;
                     end
                  end
               end
               GAP: begin
                  if (gap_q == GW'(2 * HALF_PERIOD - 1)) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     row_q   <= '0;
                     color_q <= '0;
                     bit_q   <= '0;
                     gap_q   <= '0;
                  end else begin
                     gap_q <= gap_q + 1'b1;
                  end
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign LAT     = lat_q;
   assign angle   = angle_q;
   assign row     = row_q;
   assign color   = color_q;
   assign bit_sel = bit_q;
   assign busy    = busy_q;
   assign overrun = ovr_q;

endmodule

// File: tb/tb_led_band_sequencer.sv
// Bench for led_band_sequencer: scoreboard of every SCLK bit,
// LAT framing, strobe/en handling, async reset and a param sweep.
module tb_led_band_sequencer;
   import led_band_pkg::*;

   localparam int NLED  = 32;
   localparam int NB    = 9;
   localparam int GS    = 3 * NB;
   localparam int NBITS = NLED * GS;
   localparam int PASS  = NBITS * 4 + 4;
   localparam int NB2   = 8;
   localparam int NBIT2 = NLED * 3 * NB2;
   localparam int PASS2 = NBIT2 * 6 + 6;

   typedef struct packed {
      logic [4:0] row;
      logic [1:0] col;
      logic [3:0] bsel;
      logic       lat;
      logic [6:0] ang;
   } rec_t;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       en = 1'b0;
   logic       angle_strobe = 1'b0;
   logic [6:0] angle_in = '0;
   logic       SCLK, LAT, busy, overrun;
   logic [6:0] angle;
   logic [4:0] row;
   logic [1:0] color;
   logic [3:0] bit_sel;

   logic       en2 = 1'b0;
   logic       strobe2 = 1'b0;
   logic [6:0] angle_in2 = 7'd1;
   logic       sclk2, lat2, busy2, ovr2;
   logic [6:0] angle2;
   logic [4:0] row2;
   logic [1:0] color2;
   logic [2:0] bit2;

   always #5 clk = ~clk;

   led_band_sequencer dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .angle_in     (angle_in),
      .angle_strobe (angle_strobe),
      .SCLK         (SCLK),
      .LAT          (LAT),
      .angle        (angle),
      .row          (row),
      .color        (color),
      .bit_sel      (bit_sel),
      .busy         (busy),
      .overrun      (overrun)
   );

   led_band_sequencer #(
      .HALF_PERIOD (3),
      .NB_0_LSB    (0)
   ) dut2 (
      .clk          (clk),
      .rst          (rst),
      .en           (en2),
      .angle_in     (angle_in2),
      .angle_strobe (strobe2),
      .SCLK         (sclk2),
      .LAT          (lat2),
      .angle        (angle2),
      .row          (row2),
      .color        (color2),
      .bit_sel      (bit2),
      .busy         (busy2),
      .overrun      (ovr2)
   );

   rec_t obs_q[$];
   rec_t exp_q[$];
   int   n_cmp = 0;
   int   n_err = 0;

   logic sclk_p = 1'b0;
   logic last_final = 1'b0;
   int   busy_cyc = 0;
   int   ovr_cyc = 0;
   int   gap_cyc = 0;
   int   lat_gap = 0;

   logic sclk2_p = 1'b0;
   int   rises2 = 0;
   int   hi_len2 = 0;
   int   hi_ph2 = 0;
   int   hi_bad2 = 0;
   int   busy2_cyc = 0;
   rec_t last2;

   int   pass_base = 0;
   int   gap_d = 0;
   int   latgap_d = 0;

   // Record every SCLK rise of the default instance.
   always @(negedge clk) begin
      rec_t r;
      r.row  = row;
      r.col  = color;
      r.bsel = bit_sel;
      r.lat  = LAT;
      r.ang  = angle;
      if (SCLK && !sclk_p) begin
         obs_q.push_back(r);
         last_final = (row == 5'd31 && color == 2'd2 && bit_sel == 4'd8);
      end
      if (!busy) last_final = 1'b0;
      if (busy && !SCLK && last_final) begin
         gap_cyc++;
         if (LAT) lat_gap++;
      end
      if (busy) busy_cyc++;
      if (overrun) ovr_cyc++;
      sclk_p = SCLK;
   end

   // Phase-length and activity monitor of the swept instance.
   always @(negedge clk) begin
      if (sclk2 && !sclk2_p) begin
         rises2++;
         last2.row  = row2;
         last2.col  = color2;
         last2.bsel = {1'b0, bit2};
         last2.lat  = lat2;
         last2.ang  = angle2;
      end
      if (sclk2) begin
         hi_len2++;
      end else begin
         if (hi_len2 > 0) begin
            hi_ph2++;
            if (hi_len2 != 3) hi_bad2++;
         end
         hi_len2 = 0;
      end
      if (busy2) busy2_cyc++;
      sclk2_p = sclk2;
   end

   task automatic push_pass(input logic [6:0] a);
      rec_t e;
      for (int r = 0; r < NLED; r++)
         for (int c = 0; c < 3; c++)
            for (int b = 0; b < NB; b++) begin
               e.row  = 5'(r);
               e.col  = 2'(c);
               e.bsel = 4'(b);
               e.lat  = (c * NB + b) >= (GS - ((r == NLED - 1) ? 3 : 1));
               e.ang  = a;
               exp_q.push_back(e);
            end
   endtask

   task automatic pulse_strobe(input logic [6:0] a);
      @(negedge clk);
      angle_in = a;
      angle_strobe = 1'b1;
      @(negedge clk);
      angle_strobe = 1'b0;
   endtask

   task automatic wait_idle(output bit to);
      to = 1'b1;
      for (int i = 0; i < 6000; i++) begin
         @(negedge clk);
         if (!busy) begin
            to = 1'b0;
            break;
         end
      end
   endtask

   task automatic test_reset();
      n_cmp++;
      if (SCLK !== 1'b0 || LAT !== 1'b0) begin
         n_err++;
         $display("FAIL reset_sclk_lat: got %b%b want 00", SCLK, LAT);
      end
      n_cmp++;
      if (busy !== 1'b0 || overrun !== 1'b0) begin
         n_err++;
         $display("FAIL reset_busy_ovr: got %b%b want 00", busy, overrun);
      end
      n_cmp++;
      if ({angle, row, color, bit_sel} !== '0) begin
         n_err++;
         $display("FAIL reset_idx: got a=%0d r=%0d c=%0d b=%0d want 0",
                  angle, row, color, bit_sel);
      end
      n_cmp++;
      if (sclk2 !== 1'b0 || busy2 !== 1'b0) begin
         n_err++;
         $display("FAIL reset_dut2: got %b%b want 00", sclk2, busy2);
      end
   endtask

   task automatic test_full_pass();
      bit to;
      int bb, gb, lb;
      rec_t e;
      pass_base = obs_q.size();
      bb = busy_cyc;
      gb = gap_cyc;
      lb = lat_gap;
      push_pass(7'd37);
      pulse_strobe(7'd37);
      wait_idle(to);
      gap_d = gap_cyc - gb;
      latgap_d = lat_gap - lb;
      n_cmp++;
      if (to) begin
         n_err++;
         $display("FAIL full_timeout: busy still 1 want 0");
      end
      n_cmp++;
      if (obs_q.size() - pass_base != NBITS) begin
         n_err++;
         $display("FAIL full_rises: got %0d want %0d",
                  obs_q.size() - pass_base, NBITS);
      end
      n_cmp++;
      if (busy_cyc - bb != PASS) begin
         n_err++;
         $display("FAIL full_busy: got %0d want %0d", busy_cyc - bb, PASS);
      end
      for (int i = pass_base; i < obs_q.size(); i++) begin
         if (exp_q.size() == 0) break;
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q[i] !== e) begin
            n_err++;
            $display("FAIL full_sb[%0d]: got %h want %h", i - pass_base,
                     obs_q[i], e);
         end
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL full_left: got %0d unmatched want 0", exp_q.size());
      end
      exp_q.delete();
      n_cmp++;
      if ({row, color, bit_sel} !== '0 || angle !== 7'd37) begin
         n_err++;
         $display("FAIL full_after: got a=%0d r=%0d c=%0d b=%0d want 37/0",
                  angle, row, color, bit_sel);
      end
   endtask

   task automatic test_lat_edges();
      int cnt[NLED];
      int want;
      for (int r = 0; r < NLED; r++) cnt[r] = 0;
      for (int i = pass_base; i < obs_q.size(); i++)
         if (i < pass_base + NBITS && obs_q[i].lat) cnt[obs_q[i].row]++;
      for (int r = 0; r < NLED; r++) begin
         want = (r == NLED - 1) ? 3 : 1;
         n_cmp++;
         if (cnt[r] != want) begin
            n_err++;
            $display("FAIL lat_row%0d: got %0d want %0d", r, cnt[r], want);
         end
      end
      n_cmp++;
      if (gap_d != 4) begin
         n_err++;
         $display("FAIL gap_len: got %0d want 4", gap_d);
      end
      n_cmp++;
      if (latgap_d != 0) begin
         n_err++;
         $display("FAIL gap_lat: got %0d want 0", latgap_d);
      end
   endtask

   task automatic test_en_low();
      bit to;
      int rb, bb, ob, base;
      rec_t e;
      en = 1'b0;
      rb = obs_q.size();
      bb = busy_cyc;
      ob = ovr_cyc;
      pulse_strobe(7'd9);
      repeat (50) @(negedge clk);
      n_cmp++;
      if (obs_q.size() != rb || busy_cyc != bb || ovr_cyc != ob) begin
         n_err++;
         $display("FAIL en_low: got rises=%0d busy=%0d ovr=%0d want 0",
                  obs_q.size() - rb, busy_cyc - bb, ovr_cyc - ob);
      end
      en = 1'b1;
      base = obs_q.size();
      push_pass(7'd5);
      pulse_strobe(7'd5);
      wait_idle(to);
      n_cmp++;
      if (to || obs_q.size() - base != NBITS) begin
         n_err++;
         $display("FAIL en_pass: got rises=%0d to=%0b want %0d",
                  obs_q.size() - base, to, NBITS);
      end
      for (int i = base; i < obs_q.size(); i++) begin
         if (exp_q.size() == 0) break;
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q[i] !== e) begin
            n_err++;
            $display("FAIL en_sb[%0d]: got %h want %h", i - base,
                     obs_q[i], e);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_overrun();
      bit to;
      int ob, base, bb;
      rec_t e;
      base = obs_q.size();
      ob = ovr_cyc;
      push_pass(7'd20);
      pulse_strobe(7'd20);
      repeat (997) @(negedge clk);
      pulse_strobe(7'd99);
      wait_idle(to);
      n_cmp++;
      if (ovr_cyc - ob != 1) begin
         n_err++;
         $display("FAIL ovr_pulse: got %0d cycles want 1", ovr_cyc - ob);
      end
      n_cmp++;
      if (to || obs_q.size() - base != NBITS) begin
         n_err++;
         $display("FAIL ovr_pass: got rises=%0d to=%0b want %0d",
                  obs_q.size() - base, to, NBITS);
      end
      for (int i = base; i < obs_q.size(); i++) begin
         if (exp_q.size() == 0) break;
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q[i] !== e) begin
            n_err++;
            $display("FAIL ovr_sb[%0d]: got %h want %h", i - base,
                     obs_q[i], e);
         end
      end
      exp_q.delete();
      base = obs_q.size();
      bb = busy_cyc;
      repeat (50) @(negedge clk);
      n_cmp++;
      if (obs_q.size() != base || busy_cyc != bb) begin
         n_err++;
         $display("FAIL ovr_no_second: got rises=%0d busy=%0d want 0",
                  obs_q.size() - base, busy_cyc - bb);
      end
   endtask

   task automatic test_abort();
      bit to;
      int base;
      logic [4:0] r_before;
      rec_t e;
      pulse_strobe(7'd44);
      repeat (499) @(negedge clk);
      r_before = row;
      en = 1'b0;
      @(negedge clk);
      n_cmp++;
      if (r_before === 5'd0) begin
         n_err++;
         $display("FAIL abort_mid: got row %0d want nonzero", r_before);
      end
      n_cmp++;
      if (SCLK !== 1'b0 || LAT !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL abort_ctl: got s=%b l=%b b=%b want 000",
                  SCLK, LAT, busy);
      end
      n_cmp++;
      if ({row, color, bit_sel} !== '0) begin
         n_err++;
         $display("FAIL abort_idx: got r=%0d c=%0d b=%0d want 0",
                  row, color, bit_sel);
      end
      repeat (5) @(negedge clk);
      en = 1'b1;
      base = obs_q.size();
      push_pass(7'd12);
      pulse_strobe(7'd12);
      wait_idle(to);
      n_cmp++;
      if (to || obs_q.size() - base != NBITS) begin
         n_err++;
         $display("FAIL abort_restart: got rises=%0d to=%0b want %0d",
                  obs_q.size() - base, to, NBITS);
      end
      for (int i = base; i < obs_q.size(); i++) begin
         if (exp_q.size() == 0) break;
         e = exp_q.pop_front();
         n_cmp++;
         if (obs_q[i] !== e) begin
            n_err++;
            $display("FAIL abort_sb[%0d]: got %h want %h", i - base,
                     obs_q[i], e);
         end
      end
      exp_q.delete();
   endtask

   task automatic test_async_reset();
      bit hi;
      pulse_strobe(7'd3);
      repeat (300) @(negedge clk);
      hi = 1'b0;
      for (int i = 0; i < 10; i++) begin
         if (SCLK) begin
            hi = 1'b1;
            break;
         end
         @(negedge clk);
      end
      n_cmp++;
      if (!hi || busy !== 1'b1) begin
         n_err++;
         $display("FAIL arst_setup: got sclk=%b busy=%b want 11", SCLK, busy);
      end
      #2;
      rst = 1'b0;
      #1;
      n_cmp++;
      if (SCLK !== 1'b0 || LAT !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL arst_ctl: got s=%b l=%b b=%b want 000",
                  SCLK, LAT, busy);
      end
      n_cmp++;
      if ({row, color, bit_sel} !== '0) begin
         n_err++;
         $display("FAIL arst_idx: got r=%0d c=%0d b=%0d want 0",
                  row, color, bit_sel);
      end
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_sweep();
      bit to;
      int rb, hb, pb, bb;
      rb = rises2;
      hb = hi_bad2;
      pb = hi_ph2;
      bb = busy2_cyc;
      en2 = 1'b1;
      @(negedge clk);
      strobe2 = 1'b1;
      @(negedge clk);
      strobe2 = 1'b0;
      to = 1'b1;
      for (int i = 0; i < 8000; i++) begin
         @(negedge clk);
         if (!busy2) begin
            to = 1'b0;
            break;
         end
      end
      n_cmp++;
      if (to || rises2 - rb != NBIT2) begin
         n_err++;
         $display("FAIL sweep_rises: got %0d to=%0b want %0d",
                  rises2 - rb, to, NBIT2);
      end
      n_cmp++;
      if (hi_ph2 - pb != NBIT2 || hi_bad2 != hb) begin
         n_err++;
         $display("FAIL sweep_high: got phases=%0d bad=%0d want %0d/0",
                  hi_ph2 - pb, hi_bad2 - hb, NBIT2);
      end
      n_cmp++;
      if (busy2_cyc - bb != PASS2) begin
         n_err++;
         $display("FAIL sweep_busy: got %0d want %0d", busy2_cyc - bb, PASS2);
      end
      n_cmp++;
      if (last2.row !== 5'd31 || last2.col !== 2'd2 || last2.bsel !== 4'd7) begin
         n_err++;
         $display("FAIL sweep_last: got r=%0d c=%0d b=%0d want 31/2/7",
                  last2.row, last2.col, last2.bsel);
      end
   endtask

   initial begin
      rst = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      rst = 1'b1;
      en = 1'b1;
      repeat (2) @(negedge clk);
      test_full_pass();
      test_lat_edges();
      test_en_low();
      test_overrun();
      test_abort();
      test_async_reset();
      test_sweep();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
